rs_add_issue: RTL and testbench

//  Reservation station for the ADD pipe. It takes up to 3 renamed add µops per cycle from rename/dispatch.
//  It holds them until both source physical registers are ready, watching the add/mul/ls result broadcasts.
//  It issues one oldest-ready µop per cycle on the registered valid_add/Pa_add/Pb_add/Pw_add/tag_ROB_add

---
 rtl/rs_add_issue_if.sv | 43 ++++
 rtl/rs_add_issue.sv | 162 ++++++++++++++++
 tb/tb_rs_add_issue.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rs_add_issue_if.sv
// Dispatch, result-broadcast and issue signals of the ADD reservation station.
// The master side is rename/dispatch plus the broadcast sources. The slave side is the RS.
interface rs_add_issue_if #(
  parameter int PW = 5,
  parameter int TW = 5
);
  logic [2:0]         valid_dp;
  logic [2:0][PW-1:0] Pa_dp;
  logic [2:0][PW-1:0] Pb_dp;
  logic [2:0]         rdy_a_dp;
  logic [2:0]         rdy_b_dp;
  logic [2:0][PW-1:0] Pw_dp;
  logic [2:0][TW-1:0] tag_ROB_dp;

  logic               valid_Result_add;
  logic [PW-1:0]      Pw_Result_add;
  logic               valid_Result_mul;
  logic [PW-1:0]      Pw_Result_mul;
  logic               valid_Result_ls;
  logic [PW-1:0]      Pw_Result_ls;
  logic               mode_ls;

  logic               full_RS;
  logic               valid_add;
  logic [PW-1:0]      Pa_add;
  logic [PW-1:0]      Pb_add;
  logic [PW-1:0]      Pw_add;
  logic [TW-1:0]      tag_ROB_add;

  modport master (
    output valid_dp, Pa_dp, Pb_dp, rdy_a_dp, rdy_b_dp, Pw_dp, tag_ROB_dp,
    output valid_Result_add, Pw_Result_add, valid_Result_mul, Pw_Result_mul,
    output valid_Result_ls, Pw_Result_ls, mode_ls,
    input  full_RS, valid_add, Pa_add, Pb_add, Pw_add, tag_ROB_add
  );

  modport slave (
    input  valid_dp, Pa_dp, Pb_dp, rdy_a_dp, rdy_b_dp, Pw_dp, tag_ROB_dp,
    input  valid_Result_add, Pw_Result_add, valid_Result_mul, Pw_Result_mul,
    input  valid_Result_ls, Pw_Result_ls, mode_ls,
    output full_RS, valid_add, Pa_add, Pb_add, Pw_add, tag_ROB_add
  );
endinterface

// File: rtl/rs_add_issue.sv
// ADD-pipe reservation station. It accepts up to 3 dispatched uops per cycle and wakes sources on result broadcasts.
// Each cycle it issues the oldest ready uop through a registered issue port.
module rs_add_issue #(
  parameter int DEPTH = 8,
  parameter int PW    = 5,
  parameter int TW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          freeze_front,
  input  logic          freeze_back,
  rs_add_issue_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [DEPTH-1:0] valid, rdy_a, rdy_b;
  logic [PW-1:0]    pa  [DEPTH];
  logic [PW-1:0]    pb  [DEPTH];
  logic [PW-1:0]    pw  [DEPTH];
  logic [TW-1:0]    tag [DEPTH];
  logic [DEPTH-1:0] older [DEPTH];

  logic [CW-1:0]    free_cnt;
  logic [IW-1:0]    free_slot  [3];
  logic [IW-1:0]    alloc_slot [3];
  logic [1:0]       rank [3];
  logic             accept;
  logic             ls_load;
  logic [DEPTH-1:0] wake_a, wake_b, elig, sel_oh;
  logic [2:0]       byp_a, byp_b;
  logic [IW-1:0]    sel_idx;
  logic             any_sel;

  logic             valid_add_q;
  logic [PW-1:0]    pa_q, pb_q, pw_q;
  logic [TW-1:0]    tag_q;

  function automatic logic hit(
    input logic [PW-1:0] p,
    input logic v0, input logic [PW-1:0] t0,
    input logic v1, input logic [PW-1:0] t1,
    input logic v2, input logic [PW-1:0] t2
  );
    return (v0 && t0 == p) || (v1 && t1 == p) || (v2 && t2 == p);
  endfunction

  assign ls_load = bus.valid_Result_ls & ~bus.mode_ls;

  always_comb begin
    wake_a = '0;
    wake_b = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wake_a[i] = hit(pa[i], bus.valid_Result_add, bus.Pw_Result_add, bus.valid_Result_mul,
                      bus.Pw_Result_mul, ls_load, bus.Pw_Result_ls);
      wake_b[i] = hit(pb[i], bus.valid_Result_add, bus.Pw_Result_add, bus.valid_Result_mul,
                      bus.Pw_Result_mul, ls_load, bus.Pw_Result_ls);
    end
    byp_a = '0;
    byp_b = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      byp_a[k] = hit(bus.Pa_dp[k], bus.valid_Result_add, bus.Pw_Result_add, bus.valid_Result_mul,
                     bus.Pw_Result_mul, ls_load, bus.Pw_Result_ls);
      byp_b[k] = hit(bus.Pb_dp[k], bus.valid_Result_add, bus.Pw_Result_add, bus.valid_Result_mul,
                     bus.Pw_Result_mul, ls_load, bus.Pw_Result_ls);
    end
  end

  // The three lowest free slots. Slots are counted against the registered valid bits only,
  // so an entry that issues this cycle is not reused until the next cycle.
  always_comb begin
    free_cnt = '0;
    for (int unsigned k = 0; k < 3; k++) free_slot[k] = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid[i]) begin
        if (free_cnt < CW'(3)) free_slot[free_cnt[1:0]] = IW'(i);
        free_cnt = free_cnt + 1'b1;
      end
    end
    rank[0] = 2'd0;
    rank[1] = {1'b0, bus.valid_dp[0]};
    rank[2] = {1'b0, bus.valid_dp[0]} + {1'b0, bus.valid_dp[1]};
    for (int unsigned k = 0; k < 3; k++) alloc_slot[k] = free_slot[rank[k]];
  end

  assign bus.full_RS = free_cnt < CW'(3);
  assign accept      = ~bus.full_RS & ~freeze_front & ~flush;

  always_comb begin
    elig    = valid & rdy_a & rdy_b;
    any_sel = |elig;
    sel_oh  = '0;
    sel_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      sel_oh[i] = elig[i];
      for (int unsigned j = 0; j < DEPTH; j++)
        if (j != i && elig[j] && older[j][i]) sel_oh[i] = 1'b0;
    end
    for (int unsigned i = 0; i < DEPTH; i++)
      if (sel_oh[i]) sel_idx = IW'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid       <= '0;
      rdy_a       <= '0;
      rdy_b       <= '0;
      valid_add_q <= 1'b0;
      pa_q        <= '0;
      pb_q        <= '0;
      pw_q        <= '0;
      tag_q       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pa[i]    <= '0;
        pb[i]    <= '0;
        pw[i]    <= '0;
        tag[i]   <= '0;
        older[i] <= '0;
      end
    end else if (flush) begin
      valid       <= '0;
      valid_add_q <= 1'b0;
    end else begin
      rdy_a <= rdy_a | wake_a;
      rdy_b <= rdy_b | wake_b;
      if (!freeze_back) begin
        valid_add_q <= any_sel;
        if (any_sel) begin
          pa_q           <= pa[sel_idx];
          pb_q           <= pb[sel_idx];
          pw_q           <= pw[sel_idx];
          tag_q          <= tag[sel_idx];
          valid[sel_idx] <= 1'b0;
        end
      end
      // Each new entry is first marked younger than everything (column set), then its row is cleared.
      // A later lane's writes override an earlier lane's, which keeps lane order within the cycle.
      if (accept) begin
        for (int unsigned k = 0; k < 3; k++) begin
          if (bus.valid_dp[k]) begin
            valid[alloc_slot[k]] <= 1'b1;
            pa[alloc_slot[k]]    <= bus.Pa_dp[k];
            pb[alloc_slot[k]]    <= bus.Pb_dp[k];
            pw[alloc_slot[k]]    <= bus.Pw_dp[k];
            tag[alloc_slot[k]]   <= bus.tag_ROB_dp[k];
            rdy_a[alloc_slot[k]] <= bus.rdy_a_dp[k] | byp_a[k];
            rdy_b[alloc_slot[k]] <= bus.rdy_b_dp[k] | byp_b[k];
            for (int unsigned j = 0; j < DEPTH; j++) older[j][alloc_slot[k]] <= 1'b1;
            older[alloc_slot[k]] <= '0;
          end
        end
      end
    end
  end

  assign bus.valid_add   = valid_add_q;
  assign bus.Pa_add      = pa_q;
  assign bus.Pb_add      = pb_q;
  assign bus.Pw_add      = pw_q;
  assign bus.tag_ROB_add = tag_q;
endmodule

// File: tb/tb_rs_add_issue.sv
// Bench for rs_add_issue. The reference model is an age-ordered queue of waiting uops,
// stepped once per clock and compared against the DUT on every falling edge.
module tb_rs_add_issue;
  localparam int DEPTH = 8;
  localparam int PW    = 5;
  localparam int TW    = 5;

  logic clk = 1'b0;
  logic rst, flush, freeze_front, freeze_back;

  rs_add_issue_if #(.PW(PW), .TW(TW)) bus ();

  rs_add_issue #(.DEPTH(DEPTH), .PW(PW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze_front(freeze_front),
    .freeze_back(freeze_back), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pa, pb, pw;
    logic [TW-1:0] tag;
    bit            ra, rb;
  } ent_t;

  ent_t          q[$];
  bit            m_valid;
  logic [PW-1:0] m_pa, m_pb, m_pw;
  logic [TW-1:0] m_tag;

  int n_vec     = 0;
  int n_miscmp  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit bc_hit(input logic [PW-1:0] p);
    return (bus.valid_Result_add && bus.Pw_Result_add == p) ||
           (bus.valid_Result_mul && bus.Pw_Result_mul == p) ||
           (bus.valid_Result_ls && !bus.mode_ls && bus.Pw_Result_ls == p);
  endfunction

  task automatic model_step();
    int   sel;
    bit   acc;
    ent_t e;
    if (rst) begin
      q.delete();
      m_valid = 0;
      m_pa = '0; m_pb = '0; m_pw = '0; m_tag = '0;
    end else if (flush) begin
      q.delete();
      m_valid = 0;
    end else begin
      sel = -1;
      acc = (DEPTH - q.size() >= 3) && !freeze_front;
      if (!freeze_back) begin
        foreach (q[i]) if (sel < 0 && q[i].ra && q[i].rb) sel = i;
        m_valid = (sel >= 0);
        if (sel >= 0) begin
          m_pa = q[sel].pa; m_pb = q[sel].pb; m_pw = q[sel].pw; m_tag = q[sel].tag;
        end
      end
      foreach (q[i]) begin
        if (bc_hit(q[i].pa)) q[i].ra = 1;
        if (bc_hit(q[i].pb)) q[i].rb = 1;
      end
      if (sel >= 0) q.delete(sel);
      if (acc) begin
        for (int k = 0; k < 3; k++) begin
          if (bus.valid_dp[k]) begin
            e.pa  = bus.Pa_dp[k];
            e.pb  = bus.Pb_dp[k];
            e.pw  = bus.Pw_dp[k];
            e.tag = bus.tag_ROB_dp[k];
            e.ra  = bus.rdy_a_dp[k] || bc_hit(bus.Pa_dp[k]);
            e.rb  = bus.rdy_b_dp[k] || bc_hit(bus.Pb_dp[k]);
            q.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("full_RS", 32'(bus.full_RS), 32'((DEPTH - q.size()) < 3));
    chk("valid_add", 32'(bus.valid_add), 32'(m_valid));
    if (m_valid) begin
      chk("Pa_add", 32'(bus.Pa_add), 32'(m_pa));
      chk("Pb_add", 32'(bus.Pb_add), 32'(m_pb));
      chk("Pw_add", 32'(bus.Pw_add), 32'(m_pw));
      chk("tag_ROB_add", 32'(bus.tag_ROB_add), 32'(m_tag));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic clr_in();
    rst = 0; flush = 0; freeze_front = 0; freeze_back = 0;
    bus.valid_dp = '0; bus.Pa_dp = '0; bus.Pb_dp = '0; bus.Pw_dp = '0;
    bus.rdy_a_dp = '0; bus.rdy_b_dp = '0; bus.tag_ROB_dp = '0;
    bus.valid_Result_add = 0; bus.Pw_Result_add = '0;
    bus.valid_Result_mul = 0; bus.Pw_Result_mul = '0;
    bus.valid_Result_ls = 0; bus.Pw_Result_ls = '0; bus.mode_ls = 0;
  endtask

  task automatic disp(input int k, input logic [PW-1:0] pa, input logic [PW-1:0] pb,
                      input logic [PW-1:0] pw, input logic [TW-1:0] tag,
                      input bit ra, input bit rb);
    bus.valid_dp[k] = 1'b1;
    bus.Pa_dp[k] = pa; bus.Pb_dp[k] = pb; bus.Pw_dp[k] = pw;
    bus.tag_ROB_dp[k] = tag; bus.rdy_a_dp[k] = ra; bus.rdy_b_dp[k] = rb;
  endtask

  task automatic flush_all();
    clr_in(); flush = 1; tick(); clr_in();
  endtask

  initial begin
    clr_in();
    rst = 1;
    @(negedge clk);
    tick();
    chk("rst_valid_add", 32'(bus.valid_add), 32'd0);
    chk("rst_full_RS", 32'(bus.full_RS), 32'd0);
    chk("rst_Pa_add", 32'(bus.Pa_add), 32'd0);
    chk("rst_tag_ROB_add", 32'(bus.tag_ROB_add), 32'd0);
    clr_in();

    // a ready uop issues on the edge after it is dispatched
    disp(0, 5'd3, 5'd4, 5'd9, 5'd2, 1, 1); tick(); clr_in(); tick();
    chk("t1_valid", 32'(bus.valid_add), 32'd1);
    chk("t1_Pa", 32'(bus.Pa_add), 32'd3);
    chk("t1_Pw", 32'(bus.Pw_add), 32'd9);
    chk("t1_tag", 32'(bus.tag_ROB_add), 32'd2);

    // a mul broadcast makes a waiting source ready; issue follows 2 edges after the pulse
    disp(0, 5'd7, 5'd1, 5'd10, 5'd3, 0, 1); tick(); clr_in(); tick(); tick();
    bus.valid_Result_mul = 1; bus.Pw_Result_mul = 5'd7; tick(); clr_in();
    chk("t2_edge1", 32'(bus.valid_add), 32'd0);
    tick();
    chk("t2_edge2", 32'(bus.valid_add), 32'd1);
    chk("t2_tag", 32'(bus.tag_ROB_add), 32'd3);

    // a store broadcast does not wake; a load broadcast does
    disp(0, 5'd5, 5'd1, 5'd11, 5'd4, 0, 1); tick(); clr_in();
    bus.valid_Result_ls = 1; bus.Pw_Result_ls = 5'd5; bus.mode_ls = 1; tick(); clr_in();
    tick(); tick();
    chk("t3_store", 32'(bus.valid_add), 32'd0);
    bus.valid_Result_ls = 1; bus.Pw_Result_ls = 5'd5; bus.mode_ls = 0; tick(); clr_in(); tick();
    chk("t3_load", 32'(bus.valid_add), 32'd1);
    chk("t3_tag", 32'(bus.tag_ROB_add), 32'd4);

    // fill until full; a third group is dropped
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 3; k++) disp(k, 5'(16 + g), 5'd1, 5'(g * 3 + k), 5'(8 + g * 3 + k), 0, 1);
      tick(); clr_in();
    end
    chk("t4_full", 32'(bus.full_RS), 32'd1);
    for (int g = 0; g < 3; g++) begin
      bus.valid_Result_add = 1; bus.Pw_Result_add = 5'(16 + g); tick(); clr_in();
      tick(); tick(); tick();
    end
    chk("t4_drained_full", 32'(bus.full_RS), 32'd0);

    // three ready uops in one group issue in lane order, freeze_back holding the outputs
    flush_all();
    for (int k = 0; k < 3; k++) disp(k, 5'd1, 5'd2, 5'(k + 20), 5'(k), 1, 1);
    tick(); clr_in(); tick();
    chk("t5_first", 32'(bus.tag_ROB_add), 32'd0);
    freeze_back = 1; tick(); tick();
    chk("t5_hold_valid", 32'(bus.valid_add), 32'd1);
    chk("t5_hold_tag", 32'(bus.tag_ROB_add), 32'd0);
    freeze_back = 0; tick();
    chk("t5_second", 32'(bus.tag_ROB_add), 32'd1);
    tick();
    chk("t5_third", 32'(bus.tag_ROB_add), 32'd2);
    tick();

    // flush with 5 waiting entries and an issue in flight
    for (int k = 0; k < 3; k++) disp(k, 5'd30, 5'd1, 5'(k), 5'(k), 0, 1);
    tick(); clr_in();
    disp(0, 5'd30, 5'd1, 5'd3, 5'd3, 0, 1);
    disp(1, 5'd30, 5'd1, 5'd4, 5'd4, 0, 1);
    disp(2, 5'd1, 5'd1, 5'd5, 5'd5, 1, 1);
    tick(); clr_in(); tick();
    chk("t6_pre_valid", 32'(bus.valid_add), 32'd1);
    flush = 1; tick(); clr_in();
    chk("t6_valid", 32'(bus.valid_add), 32'd0);
    chk("t6_full", 32'(bus.full_RS), 32'd0);
    disp(0, 5'd2, 5'd3, 5'd6, 5'd17, 1, 1); tick(); clr_in(); tick();
    chk("t6_reissue", 32'(bus.tag_ROB_add), 32'd17);
    tick();

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      clr_in();
      rst          = (c == 400);
      flush        = ($urandom_range(0, 49) == 0);
      freeze_front = ($urandom_range(0, 9) == 0);
      freeze_back  = ($urandom_range(0, 6) == 0);
      for (int k = 0; k < 3; k++)
        if ($urandom_range(0, 2) == 0)
          disp(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
      bus.valid_Result_add = ($urandom_range(0, 2) == 0);
      bus.Pw_Result_add    = 5'($urandom_range(0, 7));
      bus.valid_Result_mul = ($urandom_range(0, 3) == 0);
      bus.Pw_Result_mul    = 5'($urandom_range(0, 7));
      bus.valid_Result_ls  = ($urandom_range(0, 3) == 0);
      bus.Pw_Result_ls     = 5'($urandom_range(0, 7));
      bus.mode_ls          = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule
